// File: rtl/mips_control_unit.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select, write enable and ALU control code as a Moore function of state.
module mips_control_unit #(
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCT_WIDTH    = 6,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int STATE_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [FUNCT_WIDTH-1:0]    funct,
    input  logic                      zero,
    output logic                      en_pc,
    output logic [1:0]                pc_src,
    output logic                      i_or_d,
    output logic                      mem_write,
    output logic                      ir_write,
    output logic                      reg_dst,
    output logic                      mem_to_reg,
    output logic                      reg_write,
    output logic                      alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
    output logic                      instr_done,
    output logic                      illegal_op,
    output logic [STATE_WIDTH-1:0]    state
);

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);

    localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'b100000);
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'b100010);
    localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'b100100);
    localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'b100101);
    localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'b101010);

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b001);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b010);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b110);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b111);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t                    cur, nxt;
    logic                      funct_ok, op_legal;
    logic [ALU_CTRL_WIDTH-1:0] funct_alu;
    logic                      pc_write, branch;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        op_legal = 1'b1;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            OP_RTYPE: op_legal = funct_ok;
            default:  op_legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                if (!op_legal)                            nxt = S_FETCH;
                else if (opcode == OP_LW || opcode == OP_SW) nxt = S_MEMADR;
                else if (opcode == OP_RTYPE)              nxt = S_EXECUTE;
                else if (opcode == OP_BEQ)                nxt = S_BRANCH;
                else if (opcode == OP_ADDI)               nxt = S_ADDIEX;
                else                                      nxt = S_JUMP;
            end
            S_MEMADR:  nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nxt = S_MEMWB;
            S_EXECUTE: nxt = S_ALUWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
    end

    // Illegal instructions are dropped in DECODE; the flag stays up until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE && !op_legal)
                illegal_op <= 1'b1;
        end
    end

    // Outputs are gated by rst_n so write enables fall the instant reset asserts.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = '0;
        instr_done = 1'b0;
        if (rst_n) begin
            case (cur)
                S_FETCH: begin
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    pc_write  = 1'b1;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMRD: i_or_d = 1'b1;
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    i_or_d     = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = funct_alu;
                end
                S_ALUWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_ctrl   = ALU_SUB;
                    pc_src     = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign en_pc = pc_write | (branch & zero);
    assign state = STATE_WIDTH'(cur);

endmodule

// File: tb/tb_mips_control_unit.sv
// Bench for mips_control_unit: per-instruction observation (state trace, write/pulse counts)
// checked against a fixed vector table and an instruction-level model under random stimulus.
module tb_mips_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       en_pc, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, instr_done, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    mips_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .en_pc(en_pc), .pc_src(pc_src), .i_or_d(i_or_d), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [31:0] seq;
        int          rw, mw, done, en;
        logic [2:0]  alu;
        logic        rdst, m2r, ill;
    } exp_t;

    typedef struct {
        logic [5:0] op, fn;
        logic       z;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t obs;
    logic ill_exp;

    wire [20:0] all_outs = {en_pc, pc_src, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg,
                            reg_write, alu_src_a, alu_src_b, alu_ctrl, instr_done, illegal_op, state};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Instruction-level model: trace and counts follow from the opcode/funct rules alone.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t e;
        e = '{lat: 2, seq: 32'h01, rw: 0, mw: 0, done: 0, en: 1, alu: 3'b010,
              rdst: 1'b0, m2r: 1'b0, ill: 1'b1};
        case (op)
            6'b100011: e = '{5, 32'h01234, 1, 0, 1, 1, 3'b010, 1'b0, 1'b1, 1'b0};
            6'b101011: e = '{4, 32'h0125,  0, 1, 1, 1, 3'b010, 1'b0, 1'b0, 1'b0};
            6'b000100: e = '{3, 32'h018,   0, 0, 1, 1 + int'(z), 3'b010, 1'b0, 1'b0, 1'b0};
            6'b001000: e = '{4, 32'h019A,  1, 0, 1, 1, 3'b010, 1'b0, 1'b0, 1'b0};
            6'b000010: e = '{3, 32'h01B,   0, 0, 1, 2, 3'b010, 1'b0, 1'b0, 1'b0};
            6'b000000: begin
                case (fn)
                    6'b100000: e.alu = 3'b010;
                    6'b100010: e.alu = 3'b110;
                    6'b100100: e.alu = 3'b000;
                    6'b100101: e.alu = 3'b001;
                    6'b101010: e.alu = 3'b111;
                    default:   e.ill = 1'b1;
                endcase
                if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                    e = '{4, 32'h0167, 1, 0, 1, 1, e.alu, 1'b1, 1'b0, 1'b0};
            end
            default: ;
        endcase
        return e;
    endfunction

    // Called at a negedge while in FETCH; returns at the next negedge that shows FETCH again.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op; funct = fn; zero = z;
        obs = '{0, 32'h0, 0, 0, 0, 0, 3'b000, 1'b0, 1'b0, 1'b0};
        do begin
            obs.lat++;
            obs.seq = {obs.seq[27:0], state};
            if (reg_write) begin obs.rw++; obs.rdst = reg_dst; obs.m2r = mem_to_reg; end
            if (mem_write)  obs.mw++;
            if (instr_done) obs.done++;
            if (en_pc)      obs.en++;
            if (state == 4'd6) obs.alu = alu_ctrl;
            @(negedge clk);
        end while (state != 4'd0 && obs.lat < 12);
        obs.ill = illegal_op;
    endtask

    task automatic compare(input string tag, input exp_t e, input logic ill_sticky);
        check({tag, ".latency"}, obs.lat, e.lat);
        check({tag, ".states"}, obs.seq, e.seq);
        check({tag, ".reg_write"}, obs.rw, e.rw);
        check({tag, ".mem_write"}, obs.mw, e.mw);
        check({tag, ".instr_done"}, obs.done, e.done);
        check({tag, ".en_pc"}, obs.en, e.en);
        if (e.seq == 32'h0167) check({tag, ".alu_ctrl"}, obs.alu, e.alu);
        if (e.rw != 0) begin
            check({tag, ".reg_dst"}, obs.rdst, e.rdst);
            check({tag, ".mem_to_reg"}, obs.m2r, e.m2r);
        end
        check({tag, ".illegal_op"}, obs.ill, ill_sticky);
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0;

        vecs.push_back('{6'b100011, 6'h00, 1'b0, '{5, 32'h01234, 1, 0, 1, 1, 3'b010, 1'b0, 1'b1, 1'b0}});
        vecs.push_back('{6'b000000, 6'b100010, 1'b0, '{4, 32'h0167, 1, 0, 1, 1, 3'b110, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{6'b000000, 6'b101010, 1'b1, '{4, 32'h0167, 1, 0, 1, 1, 3'b111, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{6'b000000, 6'b100000, 1'b0, '{4, 32'h0167, 1, 0, 1, 1, 3'b010, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{6'b000000, 6'b100100, 1'b0, '{4, 32'h0167, 1, 0, 1, 1, 3'b000, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{6'b000000, 6'b100101, 1'b0, '{4, 32'h0167, 1, 0, 1, 1, 3'b001, 1'b1, 1'b0, 1'b0}});
        vecs.push_back('{6'b000100, 6'h00, 1'b1, '{3, 32'h018, 0, 0, 1, 2, 3'b010, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{6'b000100, 6'h00, 1'b0, '{3, 32'h018, 0, 0, 1, 1, 3'b010, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{6'b101011, 6'h00, 1'b1, '{4, 32'h0125, 0, 1, 1, 1, 3'b010, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{6'b000010, 6'h00, 1'b0, '{3, 32'h01B, 0, 0, 1, 2, 3'b010, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{6'b001000, 6'h00, 1'b1, '{4, 32'h019A, 1, 0, 1, 1, 3'b010, 1'b0, 1'b0, 1'b0}});
        vecs.push_back('{6'b111111, 6'h00, 1'b0, '{2, 32'h01, 0, 0, 0, 1, 3'b010, 1'b0, 1'b0, 1'b1}});
        vecs.push_back('{6'b000000, 6'b000000, 1'b0, '{2, 32'h01, 0, 0, 0, 1, 3'b010, 1'b0, 1'b0, 1'b1}});

        // Reset held three cycles with every output low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset.outputs", all_outs, 21'h0);
        end
        rst_n = 1'b1;
        #1;
        check("release.state", state, 4'd0);
        check("release.ir_write", ir_write, 1'b1);
        check("release.en_pc", en_pc, 1'b1);
        check("release.alu_src_b", alu_src_b, 2'b01);
        check("release.alu_ctrl", alu_ctrl, 3'b010);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].z);
            compare($sformatf("vec%0d", i), vecs[i].e, vecs[i].e.ill);
        end

        // beq: en_pc follows zero combinationally within BRANCH.
        opcode = 6'b000100; funct = '0; zero = 1'b1;
        @(negedge clk); @(negedge clk);
        check("beq.state", state, 4'd8);
        check("beq.en_pc_taken", en_pc, 1'b1);
        check("beq.pc_src", pc_src, 2'b01);
        check("beq.alu_ctrl", alu_ctrl, 3'b110);
        zero = 1'b0;
        #1;
        check("beq.en_pc_not_taken", en_pc, 1'b0);
        @(negedge clk);
        check("beq.back_to_fetch", state, 4'd0);

        // Reset asserted in MEMRD and again in MEMWB: writes drop at once, flag clears.
        opcode = 6'b100011; zero = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("rst_mid.memrd_state", state, 4'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid.memrd_outputs", all_outs, 21'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
        check("rst_mid.memwb_reg_write", reg_write, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.memwb_outputs", all_outs, 21'h0);
        @(negedge clk);
        check("rst_mid.held_outputs", all_outs, 21'h0);
        rst_n = 1'b1;
        #1;
        check("rst_mid.fetch_state", state, 4'd0);
        check("rst_mid.fetch_ir_write", ir_write, 1'b1);

        ill_exp = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            logic       z;
            exp_t       e;
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000100;
                3: op = 6'b001000;
                4: op = 6'b000010;
                5, 6: op = 6'b000000;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            z = 1'($urandom);
            e = model(op, fn, z);
            ill_exp = ill_exp | e.ill;
            run_instr(op, fn, z);
            compare($sformatf("rand%0d", n), e, ill_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_control_unit.md
Name: mips_control_unit

Overview:
- Main control FSM for the multi-cycle, non-pipelined MIPS core. Sequences the PC register, instruction/data memory port, register file and ALU through fetch/decode/execute/memory/writeback.
- Receives opcode/funct from the instruction register and the ALU zero flag. Drives every datapath mux select and write enable, the ALU control code and the PC enable (en_pc).
- Instantiated inside the MIPS top alongside PC_reg and register_file.

Parameters:
- OPCODE_WIDTH, 6, instruction opcode field width
- FUNCT_WIDTH, 6, R-type funct field width
- ALU_CTRL_WIDTH, 3, ALU operation select width
- STATE_WIDTH, 4, width of the debug state output

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  OPCODE_WIDTH  IR[31:26]
- funct  input  FUNCT_WIDTH  IR[5:0]
- zero  input  1  ALU zero flag (combinational, current cycle)
- en_pc  output  1  PC register enable
- pc_src  output  2  next_pc select: 00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  output  1  memory address select: 0 PC, 1 ALUOut
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction register load enable
- reg_dst  output  1  rf A3 select: 0 rt, 1 rd
- mem_to_reg  output  1  rf WD3 select: 0 ALUOut, 1 memory data
- reg_write  output  1  rf WE3
- alu_src_a  output  1  0 PC, 1 register A
- alu_src_b  output  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2
- alu_ctrl  output  ALU_CTRL_WIDTH  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- instr_done  output  1  one-cycle pulse in the final state of a legal instruction
- illegal_op  output  1  sticky flag: an unsupported opcode or funct was decoded
- state  output  STATE_WIDTH  current FSM state (debug)

Behaviour:
- Single Moore FSM; state register reset asynchronously to FETCH. While rst_n=0, every output is forced to 0, including illegal_op. FETCH is the first active state after reset release.
- State encodings and asserted outputs (all unlisted outputs are 0):
  - FETCH=0: i_or_d=0, ir_write, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00, pc_write.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target into ALUOut).
  - MEMADR=2: alu_src_a=1, alu_src_b=10, ADD.
  - MEMRD=3: i_or_d=1.
  - MEMWB=4: reg_dst=0, mem_to_reg=1, reg_write.
  - MEMWR=5: i_or_d=1, mem_write.
  - EXECUTE=6: alu_src_a=1, alu_src_b=00, alu_ctrl=funct-decoded.
  - ALUWB=7: reg_dst=1, mem_to_reg=0, reg_write.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, branch.
  - ADDIEX=9: alu_src_a=1, alu_src_b=10, ADD.
  - ADDIWB=10: reg_dst=0, mem_to_reg=0, reg_write.
  - JUMP=11: pc_src=10, pc_write.
- en_pc = pc_write | (branch & zero), combinational. zero is sampled in the same cycle as BRANCH.
- Transitions:
  - FETCH -> DECODE always.
  - DECODE dispatches on opcode: 100011 lw / 101011 sw -> MEMADR; 000000 R-type -> EXECUTE; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP.
  - MEMADR -> MEMRD (lw) or MEMWR (sw). MEMRD -> MEMWB.
  - EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Funct decode (R-type only): 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Illegal handling: an unsupported opcode, or R-type with unsupported funct, is detected in DECODE. The FSM goes DECODE -> FETCH, sets illegal_op from the next edge, and asserts no write enable for that instruction and no instr_done. illegal_op clears only on reset.
- instr_done: asserted for exactly one cycle in MEMWB, MEMWR, ALUWB, BRANCH (taken or not), ADDIWB and JUMP.
- Reset mid-instruction: the FSM returns to FETCH immediately and all write enables drop asynchronously. No partial register or memory write may follow reset assertion.
- Unused encodings 12-15: next state FETCH, all outputs 0.

Test Plan:
- Reset held 3 cycles then released -> all outputs 0 during reset. Cycle 1 after release: state=0, ir_write=1, en_pc=1, alu_src_b=01, alu_ctrl=010.
- opcode=100011 -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. instr_done is high only in state 4.
- opcode=000000 with funct 100010, then funct 101010 -> EXECUTE has alu_ctrl=110, then 111. ALUWB has reg_dst=1, reg_write=1. 4 cycles each.
- opcode=000100 with zero=1 in BRANCH -> en_pc=1, pc_src=01. Repeat with zero=0 -> en_pc=0. Both take 3 cycles.
- opcode=101011 then 000010 -> sw: states 0,1,2,5 with mem_write=1 only in state 5. j: states 0,1,11 with en_pc=1 and pc_src=10 in state 11.
- opcode=111111, then R-type funct=000000, then rst_n pulsed low during state 3 -> return to FETCH after DECODE with no writes, illegal_op=1 sticky. Reset drops reg_write/mem_write immediately and clears illegal_op; FETCH follows release.
